// File: rtl/core_mem_responder_pkg.sv
// Shared types and helpers for the core memory responder: address/data widths,
// word indexing, byte-enable merge and the write-buffer entry.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - 3;

  typedef struct packed {
    logic              valid;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wbuf_t;

  // Full word index; the caller range-checks the bits above its array depth.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:3];
  endfunction

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] new_word,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_word;
    for (int i = 0; i < BE_W; i++)
      if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/core_mem_responder_read_pipe.sv
// Fixed-latency read data shift register; stage 0 captures the array sample.
module read_pipe
  import mem_pkg::*;
#(
  parameter int LOAD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [LOAD_LATENCY-1:0][DATA_W-1:0] stg;

  generate
    if (LOAD_LATENCY == 1) begin : g_one
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stg <= '0;
        else     stg <= d;
      end
    end else begin : g_shift
      always_ff @(posedge clk or posedge rst) begin
        if (rst) stg <= '0;
        else     stg <= {stg[LOAD_LATENCY-2:0], d};
      end
    end
  endgenerate

  assign q = stg[LOAD_LATENCY-1];

endmodule

// File: rtl/core_mem_responder.sv
// Word-organised data memory with instruction and data read ports, a byte-enabled
// core write port and a boot write port; colliding core writes park in a 1-entry buffer.
module core_mem_responder
  import mem_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int DEPTH_W      = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_to_mem,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  st_data,
  input  logic [BE_W-1:0]    we,
  input  logic               boot_we,
  input  logic [DEPTH_W-1:0] boot_addr,
  input  logic [DATA_W-1:0]  boot_data,
  output logic [DATA_W-1:0]  ld_data_for_inst,
  output logic [DATA_W-1:0]  ld_data,
  output logic               wbuf_valid,
  output logic               mem_err
);

  localparam int WORDS = 1 << DEPTH_W;

  logic [DATA_W-1:0] mem [WORDS];
  wbuf_t             wbuf;

  logic [IDX_W-1:0]  rd_idx    [2];
  logic [DATA_W-1:0] rd_sample [2];
  logic [IDX_W-1:0]  d_idx;
  logic              d_in_range;
  logic              core_wr;
  logic              wr_oob;
  logic              same_word;

  assign d_idx      = word_idx(mem_addr);
  assign d_in_range = (d_idx >> DEPTH_W) == '0;
  assign core_wr    = (|we) && d_in_range;
  assign wr_oob     = (|we) && !d_in_range;
  assign same_word  = wbuf.idx == d_idx;

  assign rd_idx[0] = word_idx(pc_to_mem);
  assign rd_idx[1] = d_idx;

  // Read-first sample; a parked write overrides its enabled bytes.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_sample[p] = '0;
      if ((rd_idx[p] >> DEPTH_W) == '0) begin
        rd_sample[p] = mem[rd_idx[p][DEPTH_W-1:0]];
        if (wbuf.valid && wbuf.idx == rd_idx[p])
          rd_sample[p] = byte_merge(rd_sample[p], wbuf.data, wbuf.be);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (boot_we) begin
        mem[boot_addr] <= boot_data;
      end else if (wbuf.valid) begin
        if (core_wr && same_word) begin
          mem[wbuf.idx[DEPTH_W-1:0]] <= byte_merge(
            byte_merge(mem[wbuf.idx[DEPTH_W-1:0]], wbuf.data, wbuf.be), st_data, we);
        end else begin
          mem[wbuf.idx[DEPTH_W-1:0]] <=
            byte_merge(mem[wbuf.idx[DEPTH_W-1:0]], wbuf.data, wbuf.be);
          if (core_wr)
            mem[d_idx[DEPTH_W-1:0]] <= byte_merge(mem[d_idx[DEPTH_W-1:0]], st_data, we);
        end
      end else if (core_wr) begin
        mem[d_idx[DEPTH_W-1:0]] <= byte_merge(mem[d_idx[DEPTH_W-1:0]], st_data, we);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf    <= '0;
      mem_err <= 1'b0;
    end else begin
      if (wr_oob) mem_err <= 1'b1;
      if (boot_we) begin
        if (core_wr) begin
          if (!wbuf.valid) wbuf <= '{valid: 1'b1, idx: d_idx, data: st_data, be: we};
          else             mem_err <= 1'b1;
        end
      end else begin
        wbuf.valid <= 1'b0;
      end
    end
  end

  assign wbuf_valid = wbuf.valid;

  read_pipe #(.LOAD_LATENCY(LOAD_LATENCY)) u_inst_pipe (
    .clk (clk),
    .rst (rst),
    .d   (rd_sample[0]),
    .q   (ld_data_for_inst)
  );

  read_pipe #(.LOAD_LATENCY(LOAD_LATENCY)) u_data_pipe (
    .clk (clk),
    .rst (rst),
    .d   (rd_sample[1]),
    .q   (ld_data)
  );

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench: a driver pushes model-predicted read results, a monitor pops and compares.
module tb_core_mem_responder;
  import mem_pkg::*;

  localparam int LAT = 3;
  localparam int DW  = 12;
  localparam int NW  = 64;
  localparam logic [31:0] OOB = 32'h0000_8000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   pc_to_mem = OOB;
  logic [31:0]   mem_addr = OOB;
  logic [63:0]   st_data = '0;
  logic [7:0]    we = '0;
  logic          boot_we = 1'b0;
  logic [DW-1:0] boot_addr = '0;
  logic [63:0]   boot_data = '0;
  logic [63:0]   ld_data_for_inst, ld_data;
  logic          wbuf_valid, mem_err;

  always #5 clk = ~clk;

  core_mem_responder #(.LOAD_LATENCY(LAT), .DEPTH_W(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_to_mem        (pc_to_mem),
    .mem_addr         (mem_addr),
    .st_data          (st_data),
    .we               (we),
    .boot_we          (boot_we),
    .boot_addr        (boot_addr),
    .boot_data        (boot_data),
    .ld_data_for_inst (ld_data_for_inst),
    .ld_data          (ld_data),
    .wbuf_valid       (wbuf_valid),
    .mem_err          (mem_err)
  );

  typedef struct {
    logic [63:0] i;
    logic [63:0] d;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference model: word contents, the parked write, and the sticky error.
  logic [63:0] mm [longint];
  bit          m_bv = 0;
  longint      m_bidx = 0;
  logic [63:0] m_bdata = '0;
  logic [7:0]  m_bbe = '0;
  bit          m_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_merge(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int k = 0; k < 8; k++)
      if (be[7-k]) r[63-8*k -: 8] = n[63-8*k -: 8];
    return r;
  endfunction

  function automatic logic [63:0] mm_get(input longint idx);
    return mm.exists(idx) ? mm[idx] : 64'h0;
  endfunction

  function automatic logic [63:0] m_read(input logic [31:0] a);
    longint idx;
    logic [63:0] v;
    idx = longint'(a) / 8;
    if (idx >= (longint'(1) << DW)) return 64'h0;
    v = mm_get(idx);
    if (m_bv && m_bidx == idx) v = m_merge(v, m_bdata, m_bbe);
    return v;
  endfunction

  function automatic void m_edge(input bit bwe, input int baddr, input logic [63:0] bdata,
                                 input logic [31:0] a, input logic [63:0] sd, input logic [7:0] be);
    longint idx;
    bit cw, ok;
    idx = longint'(a) / 8;
    cw  = (be != 0);
    ok  = idx < (longint'(1) << DW);
    if (cw && !ok) m_err = 1;
    if (bwe) begin
      mm[baddr] = bdata;
      if (cw && ok) begin
        if (!m_bv) begin
          m_bv = 1; m_bidx = idx; m_bdata = sd; m_bbe = be;
        end else m_err = 1;
      end
    end else begin
      if (m_bv) begin
        mm[m_bidx] = m_merge(mm_get(m_bidx), m_bdata, m_bbe);
        m_bv = 0;
      end
      if (cw && ok) mm[idx] = m_merge(mm_get(idx), sd, be);
    end
  endfunction

  task automatic step(input bit bwe, input int baddr, input logic [63:0] bdata,
                      input logic [31:0] pc, input logic [31:0] a,
                      input logic [63:0] sd, input logic [7:0] be);
    @(negedge clk);
    rst = 1'b0;
    boot_we = bwe; boot_addr = DW'(baddr); boot_data = bdata;
    pc_to_mem = pc; mem_addr = a; st_data = sd; we = be;
    sb.push_back('{i: m_read(pc), d: m_read(a)});
    @(posedge clk);
    m_edge(bwe, baddr, bdata, a, sd, be);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 64'h0, OOB, OOB, 64'h0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; boot_we = 1'b0; we = '0;
    sb.delete();
    m_bv = 0; m_err = 0;
    #1;
    check("rst_inst_zero", ld_data_for_inst, 64'h0);
    check("rst_ld_zero", ld_data, 64'h0);
    check("rst_err_clear", 64'(mem_err), 64'h0);
    @(posedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return $urandom | OOB;
    return (32'($urandom_range(0, NW-1)) << 3) | ($urandom & 32'h7);
  endfunction

  // Monitor: one comparison set per rising edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst || sb.size() < LAT) begin
        check("inst_empty_pipe", ld_data_for_inst, 64'h0);
        check("ld_empty_pipe", ld_data, 64'h0);
      end else begin
        e = sb.pop_front();
        check("ld_data_for_inst", ld_data_for_inst, e.i);
        check("ld_data", ld_data, e.d);
      end
      check("wbuf_valid", 64'(wbuf_valid), 64'(m_bv));
      check("mem_err", 64'(mem_err), 64'(m_err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    for (int w = 0; w < NW; w++) step(1, w, {$urandom, $urandom}, OOB, OOB, 64'h0, 8'h00);
    idle(LAT);

    // Basic store then load of the same word.
    step(0, 0, 64'h0, OOB, 32'h40, 64'h0123_4567_89AB_CDEF, 8'hFF);
    step(0, 0, 64'h0, OOB, 32'h40, 64'h0, 8'h00);
    idle(LAT-1);
    #2 check("basic_load", ld_data, 64'h0123_4567_89AB_CDEF);

    // Single-byte merge into a cleared word, seen on both ports.
    step(1, 8, 64'h0, OOB, OOB, 64'h0, 8'h00);
    step(0, 0, 64'h0, OOB, 32'h40, 64'hAA00_0000_0000_0000, 8'h80);
    step(0, 0, 64'h0, 32'h40, 32'h40, 64'h0, 8'h00);
    idle(LAT-1);
    #2 check("merge_load", ld_data, 64'hAA00_0000_0000_0000);
    check("merge_fetch", ld_data_for_inst, 64'hAA00_0000_0000_0000);

    // Boot/core collision parks the store and forwards it.
    step(1, 5, 64'h1111, OOB, 32'h28, 64'h22, 8'h01);
    #2 check("collide_wbuf_set", 64'(wbuf_valid), 64'h1);
    step(0, 0, 64'h0, OOB, 32'h28, 64'h0, 8'h00);
    #2 check("collide_wbuf_drain", 64'(wbuf_valid), 64'h0);
    idle(LAT-1);
    #2 check("collide_forward", ld_data, 64'h1122);

    // Overflow: first store buffered, later ones dropped.
    step(1, 10, 64'h5, OOB, 32'h60, 64'h1, 8'h01);
    #2 check("ovf_first_ok", 64'(mem_err), 64'h0);
    step(1, 11, 64'h6, OOB, 32'h68, 64'h2, 8'h01);
    #2 check("ovf_err_set", 64'(mem_err), 64'h1);
    step(1, 12, 64'h7, OOB, 32'h70, 64'h3, 8'h01);
    idle(4);
    #2 check("ovf_err_sticky", 64'(mem_err), 64'h1);

    // Out-of-range load and store.
    do_reset();
    step(0, 0, 64'h0, 32'h40, OOB, 64'h0, 8'h00);
    idle(LAT-1);
    #2 check("oob_load_zero", ld_data, 64'h0);
    step(0, 0, 64'h0, OOB, OOB, 64'hFFFF, 8'hFF);
    #2 check("oob_store_err", 64'(mem_err), 64'h1);

    // Reset with loads in flight.
    do_reset();
    for (int k = 0; k < 3; k++) step(0, 0, 64'h0, 32'h40, 32'h40, 64'h0, 8'h00);
    do_reset();
    step(0, 0, 64'h0, 32'h40, 32'h40, 64'h0, 8'h00);
    #2 check("post_rst_still_zero", ld_data, 64'h0);
    idle(LAT);

    // Randomized traffic.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int k = 0; k < 200; k++) begin
        bit          bwe;
        logic [7:0]  be;
        bwe = ($urandom_range(0, 3) == 0);
        be  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
        step(bwe, int'($urandom_range(0, NW-1)), {$urandom, $urandom},
             rand_addr(), rand_addr(), {$urandom, $urandom}, be);
      end
      idle(LAT);
    end

    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
